// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the halt-triggered result UART: frame constants,
// sequencer state encoding and the bit-time helper.
package result_uart_tx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 11;

  typedef enum logic [2:0] {
    S_WATCH,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/result_uart_tx_byte.sv
// 8N1 byte serialiser. A new byte is accepted while idle or in the last cycle
// of the stop bit, so consecutive bytes leave no idle gap on the line.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_ready,
  output logic       o_bit_end,
  output logic [3:0] o_bit_idx
);

  localparam int              CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LOAD = CW'(CLKS_PER_BIT - 1);

  logic          r_busy;
  logic          r_txd;
  logic [8:0]    r_shift;
  logic [3:0]    r_bit_idx;
  logic [CW-1:0] r_baud_cnt;
  logic          w_bit_end;
  logic          w_last;

  assign w_bit_end = r_busy && (r_baud_cnt == '0);
  assign w_last    = w_bit_end && (r_bit_idx == 4'd9);

  assign o_txd     = r_txd;
  assign o_busy    = r_busy;
  assign o_ready   = !r_busy || w_last;
  assign o_bit_end = w_bit_end;
  assign o_bit_idx = r_bit_idx;

  // r_shift holds the data bits followed by the stop bit; index 0 is the start bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy     <= 1'b0;
      r_txd      <= 1'b1;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_baud_cnt <= '0;
    end else if (i_start && o_ready) begin
      r_busy     <= 1'b1;
      r_txd      <= 1'b0;
      r_shift    <= {1'b1, i_data};
      r_bit_idx  <= '0;
      r_baud_cnt <= BAUD_LOAD;
    end else if (w_last) begin
      r_busy <= 1'b0;
      r_txd  <= 1'b1;
    end else if (w_bit_end) begin
      r_txd      <= r_shift[0];
      r_shift    <= {1'b1, r_shift[8:1]};
      r_bit_idx  <= r_bit_idx + 4'd1;
      r_baud_cnt <= BAUD_LOAD;
    end else if (r_busy) begin
      r_baud_cnt <= r_baud_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Watches the CPU PC for a self-loop halt, snapshots the result outputs and
// sends them as an 11-byte UART frame: A5, attempt[4], broken[4], last, xor.
//
// state   | meaning
// S_WATCH | counting consecutive cycles of an unchanged PC
// S_START | start bit of the current byte (first byte issued here)
// S_DATA  | eight data bits of the current byte
// S_STOP  | stop bit; chains the next byte or finishes the frame
// S_DONE  | frame complete, waiting for resend or a PC change
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int HALT_CYCLES = 16
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_attempt_count,
  input  logic [31:0] in_broken_count,
  input  logic        in_is_last_broken,
  input  logic        in_resend,
  output logic        out_txd,
  output logic        out_busy,
  output logic        out_done
);

  localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam logic [7:0] HALT_CNT     = 8'(HALT_CYCLES);
  localparam logic [3:0] LAST_IDX     = 4'(FRAME_LEN - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("result_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end
  if (HALT_CYCLES < 1 || HALT_CYCLES > 255) begin : g_bad_halt
    $error("result_uart_tx: HALT_CYCLES must be in 1..255");
  end

  state_e      r_state, w_next;
  logic [31:0] r_prev_pc;
  logic [7:0]  r_halt_cnt;
  logic [3:0]  r_idx;
  logic [31:0] r_att;
  logic [31:0] r_brk;
  logic        r_last;
  logic        r_done;

  logic        w_pc_same;
  logic [7:0]  w_cnt_next;
  logic        w_halt;
  logic        w_start;
  logic        w_idx_inc;
  logic        w_idx_clr;
  logic [3:0]  w_tx_idx;
  logic [7:0]  w_tx_byte;
  logic [7:0]  w_csum;
  logic        w_tx_busy;
  logic        w_tx_ready;
  logic        w_bit_end;
  logic [3:0]  w_bit_idx;

  assign w_pc_same  = (in_pc == r_prev_pc);
  assign w_cnt_next = !w_pc_same ? 8'd0 :
                      (r_halt_cnt == HALT_CNT) ? HALT_CNT : r_halt_cnt + 8'd1;
  assign w_halt     = (r_state == S_WATCH) && (w_cnt_next == HALT_CNT);

  assign w_csum = r_att[7:0] ^ r_att[15:8] ^ r_att[23:16] ^ r_att[31:24] ^
                  r_brk[7:0] ^ r_brk[15:8] ^ r_brk[23:16] ^ r_brk[31:24] ^
                  {7'b0, r_last};

  // From S_STOP the next byte is loaded back-to-back, one index ahead
  assign w_tx_idx = (r_state == S_STOP) ? r_idx + 4'd1 : r_idx;

  always_comb begin
    w_tx_byte = w_csum;
    case (w_tx_idx)
      4'd0:    w_tx_byte = SYNC_BYTE;
      4'd1:    w_tx_byte = r_att[7:0];
      4'd2:    w_tx_byte = r_att[15:8];
      4'd3:    w_tx_byte = r_att[23:16];
      4'd4:    w_tx_byte = r_att[31:24];
      4'd5:    w_tx_byte = r_brk[7:0];
      4'd6:    w_tx_byte = r_brk[15:8];
      4'd7:    w_tx_byte = r_brk[23:16];
      4'd8:    w_tx_byte = r_brk[31:24];
      4'd9:    w_tx_byte = {7'b0, r_last};
      default: w_tx_byte = w_csum;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_idx_inc = 1'b0;
    w_idx_clr = 1'b0;
    case (r_state)
      S_WATCH: if (w_halt) w_next = S_START;
      S_START: begin
        w_start = !w_tx_busy;
        if (w_bit_end && w_bit_idx == 4'd0) w_next = S_DATA;
      end
      S_DATA:  if (w_bit_end && w_bit_idx == 4'd8) w_next = S_STOP;
      S_STOP: begin
        if (w_bit_end && w_bit_idx == 4'd9) begin
          if (r_idx < LAST_IDX) begin
            w_start   = w_tx_ready;
            w_idx_inc = 1'b1;
            w_next    = S_START;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (in_resend) begin
          w_idx_clr = 1'b1;
          w_next    = S_START;
        end else if (!w_pc_same) begin
          w_next = S_WATCH;
        end
      end
      default: w_next = S_WATCH;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state    <= S_WATCH;
      r_prev_pc  <= '0;
      r_halt_cnt <= '0;
      r_idx      <= '0;
      r_att      <= '0;
      r_brk      <= '0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_prev_pc <= in_pc;
      r_done    <= (w_next == S_DONE);
      if (r_state == S_WATCH) begin
        r_halt_cnt <= w_cnt_next;
      end else if (r_state == S_DONE && w_next == S_WATCH) begin
        r_halt_cnt <= '0;
      end
      if (w_halt) begin
        r_att  <= in_attempt_count;
        r_brk  <= in_broken_count;
        r_last <= in_is_last_broken;
        r_idx  <= '0;
      end else if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
    .i_clk    (in_clk),
    .i_rst_n  (in_rst),
    .i_start  (w_start),
    .i_data   (w_tx_byte),
    .o_txd    (out_txd),
    .o_busy   (w_tx_busy),
    .o_ready  (w_tx_ready),
    .o_bit_end(w_bit_end),
    .o_bit_idx(w_bit_idx)
  );

  assign out_busy = w_tx_busy;
  assign out_done = r_done;

endmodule
